xadc_aux_scan_ctrl: RTL and testbench

- Sequences the four-channel external analog multiplexer in front of the XADC auxiliary input.
- For each channel it drives the mux select, waits a settle time and discards one stale conversion, then reads the result over the XADC DRP port.
- Each result is stored as a 12-bit MEASURED_AUXn value that feeds the AXI config register block.
- It is a round-robin scan scheduler that shares one XADC input between four sensors.

---
 rtl/xadc_pkg.sv | 25 ++
 rtl/mux_sel_encode.sv | 21 ++
 rtl/xadc_aux_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_xadc_aux_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC auxiliary-input scan logic.
package xadc_pkg;

    localparam int         NUM_AUX_CH       = 4;
    localparam logic [6:0] DRP_ADDR_DEFAULT = 7'h10;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        WAIT_EOC1,
        WAIT_EOC2,
        READ,
        WAIT_DRDY,
        NEXT
    } scan_state_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_sel_encode.sv
// Turns a channel index into the external mux select, binary or one-hot.
module mux_sel_encode
    import xadc_pkg::*;
(
    input  logic [1:0]            ch,
    input  logic                  one_hot_sel,
    output logic [NUM_AUX_CH-1:0] sel
);

    // Encode the channel index in the requested select format.
    always_comb begin
        // NOTE: default first so every path assigns sel and no latch is inferred.
        sel = '0;
        if (one_hot_sel) begin
            sel[ch] = 1'b1;
        end else begin
            sel = {2'b00, ch};
        end
    end

endmodule

// File: rtl/xadc_aux_scan_ctrl.sv
// Round-robin scanner sharing the XADC aux input between four muxed sensors:
// select, settle, drop one straddling conversion, read the next over DRP.
module xadc_aux_scan_ctrl
    import xadc_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 1000,
    parameter logic [6:0] DRP_ADDR      = DRP_ADDR_DEFAULT,
    parameter int         DRDY_TIMEOUT  = 255
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic        enable,
    input  logic        one_hot_sel,
    input  logic        eoc,
    input  logic        drp_drdy,
    input  logic [15:0] drp_do,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [6:0]  drp_daddr,
    output logic [3:0]  mux_sel,
    output logic [11:0] MEASURED_AUX0,
    output logic [11:0] MEASURED_AUX1,
    output logic [11:0] MEASURED_AUX2,
    output logic [11:0] MEASURED_AUX3,
    output logic        busy,
    output logic        scan_done,
    output logic        drp_err
);

    localparam int SETTLE_W = cnt_width(SETTLE_CYCLES);
    localparam int TMO_W    = cnt_width(DRDY_TIMEOUT);

    scan_state_t          state;
    logic [1:0]           ch;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [11:0]          measured [NUM_AUX_CH];
    logic [3:0]           sel_enc;
    logic                 unused_do_lsbs;

    // The ADC result is left-justified; the low nibble carries no data.
    assign unused_do_lsbs = ^drp_do[3:0];

    assign drp_dwe   = 1'b0;
    assign drp_daddr = DRP_ADDR;

    assign MEASURED_AUX0 = measured[0];
    assign MEASURED_AUX1 = measured[1];
    assign MEASURED_AUX2 = measured[2];
    assign MEASURED_AUX3 = measured[3];

    mux_sel_encode u_mux_sel_encode (
        .ch          (ch),
        .one_hot_sel (one_hot_sel),
        .sel         (sel_enc)
    );

    // Scan sequencer: one channel per pass SELECT..NEXT, all outputs registered.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state      <= IDLE;
            ch         <= '0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            mux_sel    <= '0;
            drp_den    <= 1'b0;
            busy       <= 1'b0;
            scan_done  <= 1'b0;
            drp_err    <= 1'b0;
            // NOTE: the result registers are visible outputs that must read 0
            // after reset, so this small array is reset like any other flop.
            for (int i = 0; i < NUM_AUX_CH; i++) begin
                measured[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout, so every branch sees the
            // pre-edge values; strobes default low and are raised per state.
            drp_den   <= 1'b0;
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    mux_sel <= '0;
                    busy    <= enable;
                    if (enable) state <= SELECT;
                end
                SELECT: begin
                    mux_sel    <= sel_enc;
                    settle_cnt <= SETTLE_W'(SETTLE_CYCLES);
                    state      <= (SETTLE_CYCLES == 0) ? WAIT_EOC1 : SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - SETTLE_W'(1);
                    if (settle_cnt <= SETTLE_W'(1)) state <= WAIT_EOC1;
                end
                WAIT_EOC1: begin
                    // This conversion may have started before the mux moved.
                    if (eoc) state <= WAIT_EOC2;
                end
                WAIT_EOC2: begin
                    if (eoc) begin
                        drp_den <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    tmo_cnt <= TMO_W'(DRDY_TIMEOUT);
                    state   <= WAIT_DRDY;
                end
                WAIT_DRDY: begin
                    if (drp_drdy) begin
                        measured[ch] <= drp_do[15:4];
                        state        <= NEXT;
                    end else if (tmo_cnt <= TMO_W'(1)) begin
                        drp_err <= 1'b1;
                        state   <= NEXT;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                NEXT: begin
                    ch        <= ch + 2'd1;
                    scan_done <= (ch == 2'(NUM_AUX_CH - 1));
                    busy      <= enable;
                    if (enable) begin
                        state <= SELECT;
                    end else begin
                        state   <= IDLE;
                        mux_sel <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_aux_scan_ctrl.sv
// Self-checking bench for xadc_aux_scan_ctrl: randomized eoc/drdy stimulus
// against a timeline model built from the per-channel latency rules.
module tb_xadc_aux_scan_ctrl;

    localparam int SETTLE = 4;
    localparam int TMO    = 255;

    logic        S_AXI_ACLK = 1'b0;
    logic        S_AXI_ARESETN;
    logic        enable;
    logic        one_hot_sel;
    logic        eoc;
    logic        drp_drdy;
    logic [15:0] drp_do;
    logic        drp_den;
    logic        drp_dwe;
    logic [6:0]  drp_daddr;
    logic [3:0]  mux_sel;
    logic [11:0] MEASURED_AUX0, MEASURED_AUX1, MEASURED_AUX2, MEASURED_AUX3;
    logic        busy;
    logic        scan_done;
    logic        drp_err;

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    xadc_aux_scan_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .DRP_ADDR      (7'h10),
        .DRDY_TIMEOUT  (TMO)
    ) dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .enable        (enable),
        .one_hot_sel   (one_hot_sel),
        .eoc           (eoc),
        .drp_drdy      (drp_drdy),
        .drp_do        (drp_do),
        .drp_den       (drp_den),
        .drp_dwe       (drp_dwe),
        .drp_daddr     (drp_daddr),
        .mux_sel       (mux_sel),
        .MEASURED_AUX0 (MEASURED_AUX0),
        .MEASURED_AUX1 (MEASURED_AUX1),
        .MEASURED_AUX2 (MEASURED_AUX2),
        .MEASURED_AUX3 (MEASURED_AUX3),
        .busy          (busy),
        .scan_done     (scan_done),
        .drp_err       (drp_err)
    );

    typedef enum {M_IDLE, M_SCAN, M_DRP} mphase_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          edge_n   = 0;
    mphase_t     mph      = M_IDLE;
    int          k_sel, eoc_seen, den_edge, resp_edge, next_edge;
    bit          resp_drop;
    int          m_ch     = 0;
    logic [11:0] m_mem [4];
    bit          m_err    = 1'b0;
    bit          m_hot    = 1'b0;
    logic [15:0] cur_do;
    int          scans    = 0;
    bit          hot_mode   = 1'b0;
    bit          toggle_en  = 1'b0;
    bit          rand_eoc   = 1'b0;
    bit          rand_delay = 1'b0;
    bit          drop_ch2   = 1'b0;
    bit          first_read = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic logic [3:0] enc(input int c, input bit h);
        logic [3:0] one;
        one = 4'b0001;
        return h ? (one << c) : 4'(c);
    endfunction

    function automatic logic [11:0] meas(input int i);
        case (i)
            0:       return MEASURED_AUX0;
            1:       return MEASURED_AUX1;
            2:       return MEASURED_AUX2;
            default: return MEASURED_AUX3;
        endcase
    endfunction

    task automatic check_mem(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_aux%0d", tag, i), meas(i), m_mem[i]);
        end
    endtask

    // Drive inputs for the next edge, clock once, then update the model.
    task automatic tick();
        int n;
        bit en_s, hot_s, eoc_s, in_settle, exp_den, exp_done;
        n         = edge_n + 1;
        in_settle = (mph == M_SCAN) && (n >= k_sel + 2) && (n <= k_sel + SETTLE + 1);
        eoc_s     = (n % 20 == 0) || (rand_eoc && $urandom_range(0, 11) == 0) ||
                    ((mph == M_SCAN) && (n == k_sel + 2 || n == k_sel + SETTLE + 1));
        hot_s     = hot_mode ^ (toggle_en && in_settle);
        en_s      = enable;
        one_hot_sel = hot_s;
        eoc         = eoc_s;
        drp_drdy    = (mph == M_DRP) && (n == den_edge + 1 || (!resp_drop && n == resp_edge));
        drp_do      = (mph == M_DRP && !resp_drop && n == resp_edge) ? cur_do : 16'($urandom);
        @(posedge S_AXI_ACLK);
        #1;
        edge_n   = n;
        exp_den  = 1'b0;
        exp_done = 1'b0;
        case (mph)
            M_IDLE: begin
                if (en_s) begin
                    mph = M_SCAN; k_sel = n; eoc_seen = 0;
                    check("busy_start", busy, 1);
                end
            end
            M_SCAN: begin
                if (n == k_sel + 1) m_hot = hot_s;
                if (n == k_sel + SETTLE + 1) check("mux_hold", mux_sel, enc(m_ch, m_hot));
                if (n >= k_sel + SETTLE + 2 && eoc_s) eoc_seen++;
                if (eoc_seen == 2) begin
                    exp_den   = 1'b1;
                    den_edge  = n;
                    mph       = M_DRP;
                    resp_drop = drop_ch2 && (m_ch == 2);
                    resp_edge = n + (rand_delay ? int'($urandom_range(2, 8)) : 3);
                    next_edge = resp_drop ? n + TMO + 2 : resp_edge + 1;
                    cur_do    = first_read ? 16'hABC0 : 16'($urandom);
                    first_read = 1'b0;
                    check("mux_sel", mux_sel, enc(m_ch, m_hot));
                    check("busy", busy, 1);
                end
            end
            M_DRP: begin
                if (!resp_drop && n == resp_edge) begin
                    m_mem[m_ch] = cur_do[15:4];
                    check_mem("capture");
                    check("drp_err", drp_err, m_err);
                end
                if (resp_drop && n == den_edge + TMO + 1) begin
                    m_err = 1'b1;
                    check("drp_err_set", drp_err, 1);
                    check_mem("timeout");
                end
                if (n == next_edge) begin
                    exp_done = (m_ch == 3);
                    if (exp_done) scans++;
                    m_ch = (m_ch + 1) % 4;
                    check("busy_next", busy, en_s);
                    if (en_s) begin
                        mph = M_SCAN; k_sel = n; eoc_seen = 0;
                    end else begin
                        mph = M_IDLE;
                        check("mux_idle", mux_sel, 0);
                    end
                end
            end
            default: ;
        endcase
        if (drp_den || exp_den) check("drp_den", drp_den, exp_den);
        if (scan_done || exp_done) check("scan_done", scan_done, exp_done);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_den"}, drp_den, 0);
        check({tag, "_mux"}, mux_sel, 0);
        check({tag, "_done"}, scan_done, 0);
        check({tag, "_err"}, drp_err, 0);
        for (int i = 0; i < 4; i++) check($sformatf("%s_aux%0d", tag, i), meas(i), 0);
    endtask

    task automatic run_scan(input string tag);
        int target;
        bit reached;
        target = scans + 1;
        for (int i = 0; i < 4000 && scans < target; i++) tick();
        reached = (scans >= target);
        check({tag, "_scan_reached"}, reached, 1);
    endtask

    initial begin
        bit reached;
        for (int i = 0; i < 4; i++) m_mem[i] = '0;
        S_AXI_ARESETN = 1'b0;
        enable = 1'b0; one_hot_sel = 1'b0; eoc = 1'b0; drp_drdy = 1'b0; drp_do = '0;
        repeat (2) @(posedge S_AXI_ACLK);
        #1;
        check_all_zero("reset");
        check("drp_daddr", drp_daddr, 7'h10);
        check("drp_dwe", drp_dwe, 0);
        @(negedge S_AXI_ACLK);
        S_AXI_ARESETN = 1'b1;

        // Binary scan, fixed eoc period, drdy three clocks after den.
        enable = 1'b1;
        run_scan("binary");
        check("drp_err_clean", drp_err, 0);

        // One-hot scan with one_hot_sel glitching during SETTLE and random eoc.
        hot_mode = 1'b1; toggle_en = 1'b1; rand_eoc = 1'b1; rand_delay = 1'b1;
        run_scan("onehot");

        // Channel 2 never answers: timeout path.
        drop_ch2 = 1'b1;
        run_scan("timeout");
        drop_ch2 = 1'b0;
        check("drp_err_sticky", drp_err, 1);

        // Drop enable during WAIT_EOC2 of channel 1, then resume.
        hot_mode = 1'b0; toggle_en = 1'b0;
        for (int i = 0; i < 2000 && !(mph == M_SCAN && m_ch == 1 && eoc_seen == 1); i++) tick();
        reached = (mph == M_SCAN && m_ch == 1 && eoc_seen == 1);
        check("reach_ch1_eoc2", reached, 1);
        enable = 1'b0;
        for (int i = 0; i < 2000 && mph != M_IDLE; i++) tick();
        reached = (mph == M_IDLE);
        check("reach_idle", reached, 1);
        repeat (30) tick();
        check("idle_busy", busy, 0);
        check("idle_mux", mux_sel, 0);
        enable = 1'b1;
        run_scan("resume");

        // Asynchronous reset while waiting on DRP data.
        for (int i = 0; i < 2000 && !(mph == M_DRP && edge_n == den_edge + 1); i++) tick();
        reached = (mph == M_DRP && edge_n == den_edge + 1);
        check("reach_wait_drdy", reached, 1);
        #2;
        S_AXI_ARESETN = 1'b0;
        #1;
        check_all_zero("async_rst");
        enable = 1'b0;
        @(posedge S_AXI_ACLK);
        @(negedge S_AXI_ACLK);
        S_AXI_ARESETN = 1'b1;
        mph = M_IDLE; m_ch = 0; m_err = 1'b0;
        for (int i = 0; i < 4; i++) m_mem[i] = '0;
        enable = 1'b1;
        run_scan("post_reset");
        check("post_reset_err", drp_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
